// File: rtl/ddr_burst_prefetcher.sv
// ---------------------------------------------------------------------------
// ddr_burst_prefetcher
//
// Fill stage for the 64 x 64-bit frame-data queue. Issues fixed-length DDR
// read bursts from a burst-aligned base address and forwards each returned
// beat into the queue. A burst is requested only when the queue can absorb
// every beat still in flight plus the new burst. Handles frame start, abort
// and end-of-frame, and flushes the queue on start and on abort.
//
// Optional feature: define PREFETCH_STATS_EN to build the fifo-space stall
// counter behind stall_cycles. Without it stall_cycles is tied to zero.
//
// Ports:
//   clock, reset          clock (rising edge), asynchronous active-low reset
//   start, abort          one-cycle frame start / abort pulses
//   base_addr, num_bursts frame byte address and burst count, sampled on start
//   busy, done, error     status: not idle, frame completed, sticky overflow
//   ddr_rd, ddr_addr,     burst read request, address, constant burst length
//   ddr_burst_len
//   ddr_wait_req          DDR back-pressure on the request
//   ddr_valid, ddr_dout   returned read beats
//   fifo_enq_valid/bits   enqueue strobe and data toward the queue
//   fifo_enq_ready        queue not full
//   fifo_count            queue occupancy
//   fifo_flush            one-cycle queue flush
//   stall_cycles          cycles spent waiting for queue space
// ---------------------------------------------------------------------------
module ddr_burst_prefetcher #(
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [15:0]           num_bursts,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  ddr_rd,
   output logic [ADDR_WIDTH-1:0] ddr_addr,
   output logic [7:0]            ddr_burst_len,
   input  logic                  ddr_wait_req,
   input  logic                  ddr_valid,
   input  logic [63:0]           ddr_dout,
   output logic                  fifo_enq_valid,
   output logic [63:0]           fifo_enq_bits,
   input  logic                  fifo_enq_ready,
   input  logic [6:0]            fifo_count,
   output logic                  fifo_flush,
   output logic [15:0]           stall_cycles
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      DRAIN = 3'd2,
      ABORT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES  = ADDR_WIDTH'(BURST_LEN * 8);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = ~(BURST_BYTES - ADDR_WIDTH'(32'd1));
   localparam logic [7:0]            BURST_LEN_8  = 8'(BURST_LEN);
   localparam logic [6:0]            BURST_LEN_7  = 7'(BURST_LEN);
   localparam logic [7:0]            FIFO_DEPTH_8 = 8'(FIFO_DEPTH);

   state_t                  state_r, state_s;
   logic                    ddr_rd_r, ddr_rd_s;
   logic [ADDR_WIDTH-1:0]   ddr_addr_r, ddr_addr_s;
   logic [15:0]             remaining_r, remaining_s;
   logic [6:0]              outstanding_r, outstanding_s;
   logic                    flush_r, flush_s;
   logic                    error_r, error_s;
   logic                    busy_r, busy_s;
   logic                    done_r, done_s;

   logic                    accept_s;
   logic                    beat_s;
   logic                    space_ok_s;
   logic                    start_ok_s;
   logic                    abort_ok_s;
   logic                    forward_s;

   assign accept_s   = ddr_rd_r & ~ddr_wait_req;
   // Beats only retire in-flight credit; a stray beat with nothing in flight
   // must not wrap the counter.
   assign beat_s     = ddr_valid & (outstanding_r != 7'd0);
   // 8-bit sum: 64 + 64 + 64 still fits, so no carry is lost.
   assign space_ok_s = (({1'b0, fifo_count} + {1'b0, outstanding_r} + BURST_LEN_8) <= FIFO_DEPTH_8);
   // busy_r also covers the done cycle, so a start there is treated as busy.
   assign start_ok_s = start & (state_r == IDLE) & ~busy_r;
   assign abort_ok_s = abort & ((state_r == REQ) | (state_r == DRAIN));
   // Nothing is enqueued while the queue is being flushed.
   assign forward_s  = ((state_r == REQ) | (state_r == DRAIN)) & ~flush_r;

   assign fifo_enq_valid = ddr_valid & forward_s;
   assign fifo_enq_bits  = ddr_dout;
   assign ddr_burst_len  = BURST_LEN_8;
   assign ddr_rd         = ddr_rd_r;
   assign ddr_addr       = ddr_addr_r;
   assign fifo_flush     = flush_r;
   assign error          = error_r;
   assign busy           = busy_r;
   assign done           = done_r;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               state_s = (num_bursts == 16'd0) ? DONE : REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (abort) begin
               state_s = ABORT;
            end else if (accept_s && (remaining_r == 16'd1)) begin
               state_s = DRAIN;
            end else begin
               state_s = REQ;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_s = ABORT;
            end else if ((outstanding_r == 7'd0) && !ddr_valid) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         ABORT: begin
            if ((outstanding_r == 7'd0) && !ddr_rd_r && !ddr_valid) begin
               state_s = IDLE;
            end else begin
               state_s = ABORT;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Datapath next values: request, address, burst/beat bookkeeping, status
   always_comb begin
      ddr_rd_s      = 1'b0;
      ddr_addr_s    = ddr_addr_r;
      remaining_s   = remaining_r;
      outstanding_s = outstanding_r + (accept_s ? BURST_LEN_7 : 7'd0) - (beat_s ? 7'd1 : 7'd0);
      flush_s       = start_ok_s | abort_ok_s;
      error_s       = error_r;
      busy_s        = (state_s != IDLE) | (state_r == DONE);
      done_s        = (state_r == DONE);

      // A raised request is held until accepted, even across an abort.
      case (state_r)
         REQ: begin
            if (accept_s) begin
               ddr_rd_s = 1'b0;
            end else if (ddr_rd_r) begin
               ddr_rd_s = 1'b1;
            end else if (abort) begin
               ddr_rd_s = 1'b0;
            end else begin
               ddr_rd_s = (remaining_r != 16'd0) & space_ok_s;
            end
         end
         DRAIN, ABORT: begin
            ddr_rd_s = ddr_rd_r & ~accept_s;
         end
         default: begin
            ddr_rd_s = 1'b0;
         end
      endcase

      if (start_ok_s) begin
         ddr_addr_s  = base_addr & ALIGN_MASK;
         remaining_s = num_bursts;
      end else if (accept_s) begin
         ddr_addr_s  = ddr_addr_r + BURST_BYTES;
         remaining_s = (remaining_r != 16'd0) ? (remaining_r - 16'd1) : 16'd0;
      end else begin
         ddr_addr_s  = ddr_addr_r;
         remaining_s = remaining_r;
      end

      if (start_ok_s) begin
         error_s = 1'b0;
      end else if (ddr_valid && fifo_enq_valid && !fifo_enq_ready) begin
         error_s = 1'b1;
      end else begin
         error_s = error_r;
      end
   end

   // Datapath and status registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ddr_rd_r      <= 1'b0;
         ddr_addr_r    <= '0;
         remaining_r   <= 16'd0;
         outstanding_r <= 7'd0;
         flush_r       <= 1'b0;
         error_r       <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         ddr_rd_r      <= ddr_rd_s;
         ddr_addr_r    <= ddr_addr_s;
         remaining_r   <= remaining_s;
         outstanding_r <= outstanding_s;
         flush_r       <= flush_s;
         error_r       <= error_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
      end
   end

`ifdef PREFETCH_STATS_EN
   logic [15:0] stall_r;
   logic        stall_cond_s;

   assign stall_cond_s = (state_r == REQ) && (remaining_r != 16'd0) && !ddr_rd_r && !space_ok_s;

   // Saturating count of cycles spent waiting for queue space
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_r <= 16'd0;
      end else if (start_ok_s) begin
         stall_r <= 16'd0;
      end else if (stall_cond_s && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'd1;
      end else begin
         stall_r <= stall_r;
      end
   end

   assign stall_cycles = stall_r;
`else
   assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_burst_prefetcher.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ddr_burst_prefetcher. A DDR responder returns
// BURST_LEN beats per accepted request, a queue model tracks occupancy, and a
// scoreboard of expected beats (pushed on accept) is checked against every
// enqueue. One task per scenario.
// ---------------------------------------------------------------------------
module tb_ddr_burst_prefetcher;
   localparam int AW = 32;
   localparam int BL = 16;
   localparam int FD = 64;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [15:0]    num_bursts = 16'd0;
   logic           busy, done, error, ddr_rd;
   logic [AW-1:0]  ddr_addr;
   logic [7:0]     ddr_burst_len;
   logic           ddr_wait_req = 1'b0;
   logic           ddr_valid = 1'b0;
   logic [63:0]    ddr_dout = 64'd0;
   logic           fifo_enq_valid;
   logic [63:0]    fifo_enq_bits;
   logic           fifo_enq_ready = 1'b1;
   logic [6:0]     fifo_count = 7'd0;
   logic           fifo_flush;
   logic [15:0]    stall_cycles;

   int checks = 0;
   int errors = 0;

   int            mcount = 0;
   logic [63:0]   ddr_q[$];
   logic [63:0]   exp_q[$];
   logic [AW-1:0] acc_addr[$];
   int n_acc = 0, n_enq = 0, n_disc = 0, n_lost = 0, n_done = 0, n_flush = 0, n_rd = 0;
   int wait_left = 0, rd_hi = 0, acc_at = 0, stable_bad = 0, done_busy_bad = 0;
   bit drain_en = 1'b0, hold_beats = 1'b0, force_nrdy = 1'b0;
   logic prev_done = 1'b0;
   logic [AW-1:0] last_rd_addr = '0;
   logic s_busy, s_done, s_err, s_rd, s_flush;
   logic [AW-1:0] s_addr;

   ddr_burst_prefetcher #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .num_bursts(num_bursts),
      .busy(busy), .done(done), .error(error),
      .ddr_rd(ddr_rd), .ddr_addr(ddr_addr), .ddr_burst_len(ddr_burst_len),
      .ddr_wait_req(ddr_wait_req), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout),
      .fifo_enq_valid(fifo_enq_valid), .fifo_enq_bits(fifo_enq_bits),
      .fifo_enq_ready(fifo_enq_ready), .fifo_count(fifo_count),
      .fifo_flush(fifo_flush), .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   // One clock: observe at the falling edge, then drive next inputs after the rising edge.
   task automatic cycle();
      logic [63:0] exp_d;
      bit enq;
      bit deq;
      enq = 1'b0;
      @(negedge clock);
      s_busy = busy; s_done = done; s_err = error; s_rd = ddr_rd; s_flush = fifo_flush; s_addr = ddr_addr;
      if (reset) begin
         if (done) n_done++;
         if (done && !busy) done_busy_bad++;
         if (prev_done && !done && busy) done_busy_bad++;
         prev_done = done;
         if (fifo_flush) n_flush++;
         if (ddr_rd) begin
            n_rd++;
            if (rd_hi > 0 && ddr_addr !== last_rd_addr) stable_bad++;
            rd_hi++;
            last_rd_addr = ddr_addr;
            if (ddr_wait_req) begin
               if (wait_left > 0) wait_left--;
            end else begin
               acc_at = rd_hi;
               rd_hi = 0;
               n_acc++;
               acc_addr.push_back(ddr_addr);
               for (int i = 0; i < BL; i++) begin
                  ddr_q.push_back({ddr_addr, 32'(i)});
                  exp_q.push_back({ddr_addr, 32'(i)});
               end
            end
         end else begin
            rd_hi = 0;
         end
         if (fifo_enq_valid && !ddr_valid) begin
            checks++; errors++;
            $display("FAIL enq_without_beat: fifo_enq_valid=1 with ddr_valid=0");
         end
         if (ddr_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got %h, scoreboard empty", ddr_dout);
            end else begin
               exp_d = exp_q.pop_front();
               if (fifo_enq_valid) begin
                  checks++;
                  if (fifo_enq_bits !== exp_d) begin
                     errors++;
                     $display("FAIL enq_data: got %h expected %h", fifo_enq_bits, exp_d);
                  end
                  if (fifo_enq_ready) begin
                     n_enq++;
                     enq = 1'b1;
                  end else begin
                     n_lost++;
                  end
               end else begin
                  n_disc++;
               end
            end
         end
         deq = drain_en && (mcount > 0);
         if (fifo_flush) mcount = 0;
         else mcount = mcount + int'(enq) - int'(deq);
      end
      @(posedge clock);
      #1;
      fifo_count     = 7'(mcount);
      fifo_enq_ready = (mcount < FD) && !force_nrdy;
      ddr_wait_req   = (wait_left > 0);
      if (!hold_beats && ddr_q.size() > 0) begin
         ddr_valid = 1'b1;
         ddr_dout  = ddr_q.pop_front();
      end else begin
         ddr_valid = 1'b0;
         ddr_dout  = 64'd0;
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [15:0] n);
      base_addr = b; num_bursts = n; start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // Run until the frame is over (done seen and busy low); expiry is a failure.
   task automatic wait_idle(input int n0, input bit want_done, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         cycle();
         if (!s_busy && (!want_done || n_done > n0)) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_timeout: busy=%0b done_count=%0d", nm, s_busy, n_done - n0); end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, error, ddr_rd, fifo_flush, fifo_enq_valid} !== 6'b0 || ddr_addr !== '0 || stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b rd=%0b flush=%0b enq=%0b addr=%h stall=%0d, expected all 0",
                  busy, done, error, ddr_rd, fifo_flush, fifo_enq_valid, ddr_addr, stall_cycles);
      end
      checks++;
      if (ddr_burst_len !== 8'd16) begin errors++; $display("FAIL burst_len: got %0d expected 16", ddr_burst_len); end
      cycle(); cycle();
      reset = 1'b1;
      cycle(); cycle();
   endtask

   task automatic test_basic_frame();
      int d0;
      d0 = n_done; n_enq = 0; acc_addr.delete(); done_busy_bad = 0;
      drain_en = 1'b1;
      pulse_start(32'h1000_0040, 16'd4);
      cycle();
      checks++;
      if (!(s_flush === 1'b1 && s_busy === 1'b1 && s_rd === 1'b0)) begin
         errors++; $display("FAIL start_cycle: got flush=%0b busy=%0b rd=%0b expected 1 1 0", s_flush, s_busy, s_rd);
      end
      cycle();
      checks++;
      if (!(s_rd === 1'b1 && s_addr === 32'h1000_0000 && s_flush === 1'b0)) begin
         errors++; $display("FAIL first_req: got rd=%0b addr=%h flush=%0b expected 1 10000000 0", s_rd, s_addr, s_flush);
      end
      wait_idle(d0, 1'b1, "basic");
      checks++;
      if (acc_addr.size() != 4) begin
         errors++; $display("FAIL basic_req_count: got %0d expected 4", acc_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_addr[i] !== 32'h1000_0000 + 32'(i * 128)) begin
               errors++; $display("FAIL basic_addr%0d: got %h expected %h", i, acc_addr[i], 32'h1000_0000 + 32'(i * 128));
            end
         end
      end
      checks++;
      if (n_enq != 64) begin errors++; $display("FAIL basic_enq_count: got %0d expected 64", n_enq); end
      checks++;
      if (n_done - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", n_done - d0); end
      checks++;
      if (done_busy_bad != 0) begin errors++; $display("FAIL busy_done_align: got %0d violations expected 0", done_busy_bad); end
      checks++;
      if (exp_q.size() != 0 || s_err !== 1'b0) begin
         errors++; $display("FAIL basic_leftover: got %0d pending beats err=%0b expected 0 0", exp_q.size(), s_err);
      end
   endtask

   task automatic test_wait_req();
      int d0;
      d0 = n_done; acc_addr.delete(); stable_bad = 0; acc_at = 0;
      wait_left = 10; ddr_wait_req = 1'b1;
      pulse_start(32'h0000_0100, 16'd1);
      wait_idle(d0, 1'b1, "wait");
      checks++;
      if (acc_at != 11) begin errors++; $display("FAIL wait_accept_cycle: got %0d expected 11", acc_at); end
      checks++;
      if (stable_bad != 0) begin errors++; $display("FAIL wait_stable: got %0d changes expected 0", stable_bad); end
      checks++;
      if (acc_addr.size() != 1 || acc_addr[0] !== 32'h0000_0100) begin
         errors++; $display("FAIL wait_addr: got %0d reqs first %h expected 1 at 00000100", acc_addr.size(),
                            (acc_addr.size() > 0) ? acc_addr[0] : 32'h0);
      end
   endtask

   task automatic test_backpressure();
      int d0, r0;
      logic [15:0] st0;
      bit ok;
      d0 = n_done; n_enq = 0; n_acc = 0; acc_addr.delete(); ok = 1'b0;
      drain_en = 1'b0;
      pulse_start(32'h0000_4000, 16'd8);
      for (int i = 0; i < 1000; i++) begin
         cycle();
         if (mcount == 64) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL fill_timeout: got count %0d expected 64", mcount); end
      r0 = n_rd; st0 = stall_cycles;
      for (int i = 0; i < 10; i++) cycle();
      checks++;
      if (n_acc != 4) begin errors++; $display("FAIL fill_bursts: got %0d expected 4", n_acc); end
      checks++;
      if (n_rd != r0) begin errors++; $display("FAIL fill_no_req: got %0d request cycles expected 0", n_rd - r0); end
      checks++;
      if (s_err !== 1'b0) begin errors++; $display("FAIL fill_error: got %0b expected 0", s_err); end
`ifdef PREFETCH_STATS_EN
      checks++;
      if (stall_cycles !== st0 + 16'd10) begin errors++; $display("FAIL stall_count: got %0d expected %0d", stall_cycles, st0 + 16'd10); end
`else
      checks++;
      if (stall_cycles !== 16'd0) begin errors++; $display("FAIL stall_tied: got %0d expected 0", stall_cycles); end
`endif
      drain_en = 1'b1;
      wait_idle(d0, 1'b1, "fill");
      checks++;
      if (n_acc != 8 || n_enq != 128) begin errors++; $display("FAIL fill_total: got %0d bursts %0d beats expected 8 128", n_acc, n_enq); end
      checks++;
      if (acc_addr.size() != 8 || acc_addr[acc_addr.size() - 1] !== 32'h0000_4380) begin
         errors++; $display("FAIL fill_last_addr: got %h expected 00004380",
                            (acc_addr.size() > 0) ? acc_addr[acc_addr.size() - 1] : 32'h0);
      end
   endtask

   task automatic test_abort();
      int d0, f0, e0;
      bit ok;
      ok = 1'b0; n_acc = 0; n_disc = 0;
      drain_en = 1'b1; hold_beats = 1'b1;
      pulse_start(32'h0000_8000, 16'd2);
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (n_acc == 2) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL abort_setup_timeout: got %0d bursts expected 2", n_acc); end
      cycle();
      d0 = n_done; f0 = n_flush; e0 = n_enq;
      abort = 1'b1;
      cycle();
      abort = 1'b0; hold_beats = 1'b0;
      wait_idle(d0, 1'b0, "abort");
      checks++;
      if (n_flush - f0 != 1) begin errors++; $display("FAIL abort_flush: got %0d pulses expected 1", n_flush - f0); end
      checks++;
      if (n_disc != 32 || n_enq != e0) begin errors++; $display("FAIL abort_discard: got %0d dropped %0d enqueued expected 32 0", n_disc, n_enq - e0); end
      checks++;
      if (n_done != d0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", n_done - d0); end
      // abort while idle has no effect
      f0 = n_flush;
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      cycle(); cycle();
      checks++;
      if (s_busy !== 1'b0 || n_flush != f0) begin errors++; $display("FAIL idle_abort: got busy=%0b flushes=%0d expected 0 0", s_busy, n_flush - f0); end
   endtask

   task automatic test_zero_bursts();
      int r0;
      r0 = n_rd;
      pulse_start(32'h0000_0000, 16'd0);
      cycle();
      checks++;
      if (!(s_flush === 1'b1 && s_done === 1'b0)) begin errors++; $display("FAIL zero_flush: got flush=%0b done=%0b expected 1 0", s_flush, s_done); end
      cycle();
      checks++;
      if (!(s_done === 1'b1 && s_flush === 1'b0)) begin errors++; $display("FAIL zero_done: got done=%0b flush=%0b expected 1 0", s_done, s_flush); end
      cycle();
      checks++;
      if (s_done !== 1'b0 || s_busy !== 1'b0 || n_rd != r0) begin
         errors++; $display("FAIL zero_end: got done=%0b busy=%0b reqs=%0d expected 0 0 0", s_done, s_busy, n_rd - r0);
      end
   endtask

   task automatic test_overflow();
      int d0;
      d0 = n_done; n_lost = 0;
      drain_en = 1'b1; force_nrdy = 1'b1;
      pulse_start(32'h0000_C000, 16'd1);
      wait_idle(d0, 1'b1, "ovf");
      for (int i = 0; i < 5; i++) cycle();
      checks++;
      if (n_lost != 16) begin errors++; $display("FAIL ovf_lost: got %0d expected 16", n_lost); end
      checks++;
      if (s_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got error=%0b expected 1", s_err); end
      force_nrdy = 1'b0;
      pulse_start(32'h0000_0000, 16'd0);
      cycle();
      checks++;
      if (s_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got error=%0b expected 0", s_err); end
      cycle(); cycle();
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      ok = 1'b0; n_acc = 0;
      drain_en = 1'b1;
      pulse_start(32'h2000_0000, 16'd4);
      for (int i = 0; i < 300; i++) begin
         cycle();
         if (n_acc >= 2 && ddr_valid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL midrst_setup_timeout: got %0d bursts expected 2", n_acc); end
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, error, ddr_rd, fifo_flush, fifo_enq_valid} !== 6'b0 || ddr_addr !== '0 || stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got busy=%0b done=%0b err=%0b rd=%0b flush=%0b enq=%0b addr=%h stall=%0d, expected all 0",
                  busy, done, error, ddr_rd, fifo_flush, fifo_enq_valid, ddr_addr, stall_cycles);
      end
      ddr_q.delete(); exp_q.delete(); mcount = 0;
      ddr_valid = 1'b0; fifo_count = 7'd0;
      cycle(); cycle();
      reset = 1'b1;
      cycle(); cycle();
      checks++;
      if (s_busy !== 1'b0 || s_rd !== 1'b0) begin errors++; $display("FAIL midrst_after: got busy=%0b rd=%0b expected 0 0", s_busy, s_rd); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_wait_req();
      test_backpressure();
      test_abort();
      test_zero_bursts();
      test_overflow();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
